// File: rtl/cp0_timer_intr_pkg.sv
// Shared CP0 constants for the timer/interrupt-source block.
package cp0_timer_intr_pkg;

    typedef logic [7:0] cp0_addr_t;

    // CP0 register addresses, encoded as {rd, sel}
    localparam cp0_addr_t CR_COUNT   = 8'h48;
    localparam cp0_addr_t CR_COMPARE = 8'h58;
    localparam cp0_addr_t CR_STATUS  = 8'h60;
    localparam cp0_addr_t CR_CAUSE   = 8'h68;
    localparam cp0_addr_t CR_EPC     = 8'h70;

    // Cause field positions
    localparam int unsigned CAUSE_TI_BIT = 30;
    localparam int unsigned CAUSE_IP_MSB = 15;
    localparam int unsigned CAUSE_IP_LSB = 8;

    // Cause as seen by this block; BD and ExcCode are merged in by cp0
    function automatic logic [31:0] pack_cause(input logic ti, input logic [7:0] ip);
        logic [31:0] v;
        v                             = '0;
        v[CAUSE_TI_BIT]               = ti;
        v[CAUSE_IP_MSB:CAUSE_IP_LSB]  = ip;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer_intr_if.sv
// CP0-side bus for the timer/interrupt block: mtc0/mfc0, status fields, outputs.
interface cp0_timer_intr_if;
    logic        mtc0_we;
    logic [7:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [7:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic [5:0]  ext_int_in;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic        cause_ti;
    logic [7:0]  cause_ip;
    logic [31:0] count_o;
    logic        int_req;

    // cp0 / pipeline side
    modport master (
        output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        output ext_int_in, status_im, status_ie, status_exl,
        input  mfc0_rdata, cause_ti, cause_ip, count_o, int_req
    );

    // timer / interrupt-source side
    modport slave (
        input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        input  ext_int_in, status_im, status_ie, status_exl,
        output mfc0_rdata, cause_ti, cause_ip, count_o, int_req
    );
endinterface

// File: rtl/cp0_count_tick.sv
// Count divider, Count/Compare registers and the count==compare event detect.
module cp0_count_tick #(
    parameter int unsigned CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_match
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        w_tick_fire;
    logic        w_count_upd;
    logic [31:0] w_count_d;

    // Next count and the TI trigger: only an edge that actually changes Count can match,
    // and a Compare write on the same edge suppresses it.
    always_comb begin
        w_tick_fire = (CNT_DIV == 1) ? 1'b1 : r_tick;
        w_count_upd = i_count_we | w_tick_fire;
        w_count_d   = i_count_we ? i_wdata : r_count + 32'd1;
        o_match     = w_count_upd & ~i_compare_we & (w_count_d == r_compare);
    end

    // Divider phase and Count/Compare state; a Count write restarts the divider
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick    <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
        end else begin
            if (i_count_we) begin
                r_tick <= 1'b0;
            end else begin
                r_tick <= (CNT_DIV == 1) ? 1'b0 : ~r_tick;
            end
            if (w_count_upd) begin
                r_count <= w_count_d;
            end
            if (i_compare_we) begin
                r_compare <= i_wdata;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;

endmodule

// File: rtl/cp0_timer_intr.sv
// CP0 interrupt source: Count/Compare timer, Cause.TI, Cause.IP and the WB interrupt request.
module cp0_timer_intr
    import cp0_timer_intr_pkg::*;
#(
    parameter int unsigned CNT_DIV = 2
) (
    input logic              clk,
    input logic              resetn,
    cp0_timer_intr_if.slave  bus
);

    logic        w_count_we;
    logic        w_compare_we;
    logic        w_cause_we;
    logic        w_match;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [7:0]  w_cause_ip;
    logic [31:0] w_rdata;

    logic        r_cause_ti;
    logic [5:0]  r_hw_ip;
    logic [1:0]  r_sw_ip;

    // mtc0 address decode
    always_comb begin
        w_count_we   = bus.mtc0_we && (bus.mtc0_addr == CR_COUNT);
        w_compare_we = bus.mtc0_we && (bus.mtc0_addr == CR_COMPARE);
        w_cause_we   = bus.mtc0_we && (bus.mtc0_addr == CR_CAUSE);
    end

    cp0_count_tick #(
        .CNT_DIV (CNT_DIV)
    ) u_count_tick (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (bus.mtc0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_match      (w_match)
    );

    // TI is sticky until the next Compare write; a write on the match edge wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cause_ti <= 1'b0;
        end else if (w_compare_we) begin
            r_cause_ti <= 1'b0;
        end else if (w_match) begin
            r_cause_ti <= 1'b1;
        end
    end

    // Single sampling flop on the external lines; software IP bits from Cause writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hw_ip <= '0;
            r_sw_ip <= '0;
        end else begin
            r_hw_ip <= bus.ext_int_in;
            if (w_cause_we) begin
                r_sw_ip <= bus.mtc0_wdata[9:8];
            end
        end
    end

    // Pending bits, request and read mux; all combinational so EXL/IE act in the same cycle
    always_comb begin
        w_cause_ip = {r_hw_ip[5] | r_cause_ti, r_hw_ip[4:0], r_sw_ip};
        case (bus.mfc0_addr)
            CR_COUNT:   w_rdata = w_count;
            CR_COMPARE: w_rdata = w_compare;
            CR_CAUSE:   w_rdata = pack_cause(r_cause_ti, w_cause_ip);
            default:    w_rdata = '0;
        endcase
    end

    assign bus.cause_ti   = r_cause_ti;
    assign bus.cause_ip   = w_cause_ip;
    assign bus.count_o    = w_count;
    assign bus.mfc0_rdata = w_rdata;
    assign bus.int_req    = bus.status_ie & ~bus.status_exl & (|(w_cause_ip & bus.status_im));

endmodule

// File: tb/tb_cp0_timer_intr.sv
// Directed bench for cp0_timer_intr: vector table plus hand-written corner sequences.
module tb_cp0_timer_intr;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    cp0_timer_intr_if bus_if ();

    cp0_timer_intr #(
        .CNT_DIV (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [5:0]  ext;
        logic [7:0]  im;
        logic        ie;
        logic        exl;
        logic [31:0] e_count;
        logic        e_ti;
        logic [7:0]  e_ip;
        logic        e_int;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [7:0] waddr, input logic [31:0] wdata,
                                input logic [7:0] raddr, input logic [5:0] ext,
                                input logic [7:0] im, input logic ie, input logic exl,
                                input logic [31:0] e_count, input logic e_ti,
                                input logic [7:0] e_ip, input logic e_int,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr; v.ext = ext;
        v.im = im; v.ie = ie; v.exl = exl; v.e_count = e_count; v.e_ti = e_ti;
        v.e_ip = e_ip; v.e_int = e_int; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [7:0] waddr, input logic [31:0] wdata,
                         input logic [7:0] raddr);
        bus_if.mtc0_we    = we;
        bus_if.mtc0_addr  = waddr;
        bus_if.mtc0_wdata = wdata;
        bus_if.mfc0_addr  = raddr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 8'h48);
        bus_if.ext_int_in = '0;
        bus_if.status_im  = '0;
        bus_if.status_ie  = 1'b0;
        bus_if.status_exl = 1'b0;

        // rows: we waddr wdata raddr ext im ie exl | count ti ip int rdata
        // timer match from Compare=5
        vq.push_back(mk(1, 8'h58, 32'd5, 8'h58, 6'h0, 8'h00, 0, 0, 32'd10, 0, 8'h00, 0, 32'd5));
        vq.push_back(mk(1, 8'h48, 32'd0, 8'h48, 6'h0, 8'h00, 0, 0, 32'd0,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd0,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd1,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd1,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd2,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd2,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd3,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd3,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd4,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd4,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h0, 8'h80, 1, 0, 32'd5,  1, 8'h80, 1,
                        32'h4000_8000));
        vq.push_back(mk(1, 8'h58, 32'd100, 8'h68, 6'h0, 8'h80, 1, 0, 32'd5, 0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'd6,  0, 8'h00, 0, 32'd6));
        // compare write on the match edge, then static equality
        vq.push_back(mk(1, 8'h48, 32'd8, 8'h48, 6'h0, 8'h80, 1, 0, 32'd8,  0, 8'h00, 0, 32'd8));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'd8,  0, 8'h00, 0, 32'd8));
        vq.push_back(mk(1, 8'h58, 32'd9, 8'h58, 6'h0, 8'h80, 1, 0, 32'd9,  0, 8'h00, 0, 32'd9));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h58, 6'h0, 8'h80, 1, 0, 32'd9,  0, 8'h00, 0, 32'd9));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'd10, 0, 8'h00, 0, 32'd10));
        // wrap from all-ones with Compare=100
        vq.push_back(mk(1, 8'h58, 32'd100, 8'h58, 6'h0, 8'h80, 1, 0, 32'd10, 0, 8'h00, 0,
                        32'd100));
        vq.push_back(mk(1, 8'h48, 32'hFFFF_FFFF, 8'h48, 6'h0, 8'h80, 1, 0, 32'hFFFF_FFFF, 0,
                        8'h00, 0, 32'hFFFF_FFFF));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'hFFFF_FFFF, 0, 8'h00, 0,
                        32'hFFFF_FFFF));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'd0,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'd0,  0, 8'h00, 0, 32'd0));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h48, 6'h0, 8'h80, 1, 0, 32'd1,  0, 8'h00, 0, 32'd1));
        // external and software IP
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h04, 8'h10, 1, 0, 32'd1, 0, 8'h10, 1,
                        32'h0000_1000));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h04, 8'h10, 1, 1, 32'd2, 0, 8'h10, 0,
                        32'h0000_1000));
        vq.push_back(mk(1, 8'h68, 32'h100, 8'h68, 6'h04, 8'h10, 1, 0, 32'd2, 0, 8'h11, 1,
                        32'h0000_1100));
        vq.push_back(mk(0, 8'h00, 32'd0, 8'h68, 6'h00, 8'h01, 1, 0, 32'd3, 0, 8'h01, 1,
                        32'h0000_0100));
        vq.push_back(mk(1, 8'h60, 32'hFFFF_FFFF, 8'h60, 6'h00, 8'h01, 1, 0, 32'd3, 0, 8'h01, 1,
                        32'd0));
        vq.push_back(mk(1, 8'h68, 32'd0, 8'h68, 6'h00, 8'h01, 1, 0, 32'd4, 0, 8'h00, 0, 32'd0));

        // reset state
        #2;
        chk("rst_count", bus_if.count_o, 32'd0);
        chk("rst_rdata", bus_if.mfc0_rdata, 32'd0);
        chk("rst_ip", {24'd0, bus_if.cause_ip}, 32'd0);
        chk("rst_ti", {31'd0, bus_if.cause_ti}, 32'd0);
        chk("rst_int", {31'd0, bus_if.int_req}, 32'd0);

        // free run, 20 cycles
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) step();
        chk("free_count", bus_if.count_o, 32'd10);
        chk("free_rdata", bus_if.mfc0_rdata, 32'd10);
        chk("free_int", {31'd0, bus_if.int_req}, 32'd0);

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].waddr, vq[i].wdata, vq[i].raddr);
            bus_if.ext_int_in = vq[i].ext;
            bus_if.status_im  = vq[i].im;
            bus_if.status_ie  = vq[i].ie;
            bus_if.status_exl = vq[i].exl;
            step();
            chk($sformatf("v%0d_count", i), bus_if.count_o, vq[i].e_count);
            chk($sformatf("v%0d_ti", i), {31'd0, bus_if.cause_ti}, {31'd0, vq[i].e_ti});
            chk($sformatf("v%0d_ip", i), {24'd0, bus_if.cause_ip}, {24'd0, vq[i].e_ip});
            chk($sformatf("v%0d_int", i), {31'd0, bus_if.int_req}, {31'd0, vq[i].e_int});
            chk($sformatf("v%0d_rdata", i), bus_if.mfc0_rdata, vq[i].e_rdata);
        end

        // read during write returns the old Count
        drive(1'b1, 8'h48, 32'h1234, 8'h48);
        #1;
        chk("rdw_old", bus_if.mfc0_rdata, 32'd4);
        step();
        chk("rdw_new", bus_if.count_o, 32'h1234);
        drive(1'b0, 8'h00, 32'h0, 8'h48);

        // external line latency, then EXL masks in the same cycle
        bus_if.ext_int_in = 6'b000001;
        bus_if.status_im  = 8'h04;
        bus_if.status_ie  = 1'b1;
        bus_if.status_exl = 1'b0;
        #1;
        chk("ext_lat_ip", {24'd0, bus_if.cause_ip}, 32'd0);
        chk("ext_lat_int", {31'd0, bus_if.int_req}, 32'd0);
        step();
        chk("ext_ip", {24'd0, bus_if.cause_ip}, 32'h04);
        chk("ext_int", {31'd0, bus_if.int_req}, 32'd1);
        bus_if.status_exl = 1'b1;
        #1;
        chk("exl_int", {31'd0, bus_if.int_req}, 32'd0);

        // reach count=37 with TI set, then reset asynchronously mid-cycle
        @(negedge clk);
        bus_if.status_exl = 1'b0;
        bus_if.ext_int_in = '0;
        bus_if.status_im  = 8'h80;
        drive(1'b1, 8'h58, 32'd37, 8'h48);
        step();
        drive(1'b1, 8'h48, 32'd30, 8'h48);
        step();
        drive(1'b0, 8'h00, 32'h0, 8'h48);
        begin : wait_ti
            for (int k = 0; k < 40; k++) begin
                step();
                if (bus_if.cause_ti) disable wait_ti;
            end
        end
        chk("m37_ti", {31'd0, bus_if.cause_ti}, 32'd1);
        chk("m37_count", bus_if.count_o, 32'd37);
        chk("m37_int", {31'd0, bus_if.int_req}, 32'd1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_count", bus_if.count_o, 32'd0);
        chk("arst_ip", {24'd0, bus_if.cause_ip}, 32'd0);
        chk("arst_ti", {31'd0, bus_if.cause_ti}, 32'd0);
        chk("arst_int", {31'd0, bus_if.int_req}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("post_rst_c1", bus_if.count_o, 32'd0);
        step();
        chk("post_rst_c2", bus_if.count_o, 32'd1);
        chk("post_rst_ti", {31'd0, bus_if.cause_ti}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
